// File: rtl/irq_ctrl_if.sv
// Interrupt controller port bundle: peripheral lines, core handshake and the
// small memory-mapped register port.
interface irq_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0] src;
  logic         irq_en;
  logic         irq;
  logic [1:0]   addr;
  logic         we;
  logic [15:0]  wdata;
  logic [15:0]  rdata;

  modport master (
    output src, irq_en, addr, we, wdata,
    input  irq, rdata
  );

  modport slave (
    input  src, irq_en, addr, we, wdata,
    output irq, rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises up to 15 sources, latches them as pending,
// masks them and hands the lowest-numbered active one to the core.
module irq_ctrl #(
  parameter int N = 8
) (
  input logic      clk,
  input logic      rst,
  irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_WAIT_DIS = 2'd2,
    ST_SERVICE  = 2'd3
  } state_t;

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_s;
  logic [N-1:0] r_prev;
  logic [N-1:0] r_pend;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_edge;
  state_t       r_state;
  logic         r_irq;
  logic         r_cur_valid;
  logic [3:0]   r_cur_id;

  logic [N-1:0] w_rise;
  logic [N-1:0] w_act;
  logic [3:0]   w_sel;
  logic [N-1:0] w_sel_oh;
  logic         w_claim;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_nxt;

  assign w_rise   = r_s & ~r_prev;
  assign w_act    = r_pend & r_mask;
  assign w_sel_oh = N'(1'b1) << w_sel;
  assign w_claim  = (r_state == ST_IDLE) && bus.irq_en && (|w_act);

  // Lowest-numbered active source wins.
  always_comb begin
    w_sel = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sel = w_act[i] ? 4'(i) : w_sel;
    end
  end

  // Next pending state; a set from a fresh edge overrides W1C and claim clears.
  always_comb begin
    w_clr = '0;
    if (bus.we && (bus.addr == 2'd0)) begin
      w_clr = bus.wdata[N-1:0];
    end else begin
      w_clr = '0;
    end
    if (w_claim && (|(r_edge & w_sel_oh))) begin
      w_clr = w_clr | w_sel_oh;
    end else begin
      w_clr = w_clr;
    end
    w_pend_nxt = (r_edge & ((r_pend & ~w_clr) | w_rise)) | (~r_edge & r_s);
  end

  // Two-flop synchroniser plus previous-value stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_s     <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= bus.src;
      r_s     <= r_sync1;
      r_prev  <= r_s;
    end
  end

  // Pending, mask and edge-mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (bus.we && (bus.addr == 2'd1)) begin
        r_mask <= bus.wdata[N-1:0];
      end
      if (bus.we && (bus.addr == 2'd2)) begin
        r_edge <= bus.wdata[N-1:0];
      end
    end
  end

  // Core handshake FSM with registered request and claim record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_irq       <= 1'b0;
      r_cur_valid <= 1'b0;
      r_cur_id    <= 4'd0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_claim) begin
            r_state     <= ST_FIRE;
            r_irq       <= 1'b1;
            r_cur_valid <= 1'b1;
            r_cur_id    <= w_sel;
          end
        end
        ST_FIRE: begin
          r_state <= ST_WAIT_DIS;
        end
        ST_WAIT_DIS: begin
          if (!bus.irq_en) begin
            r_state <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (bus.irq_en) begin
            r_state     <= ST_IDLE;
            r_cur_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register read mux, unused upper bits zero.
  always_comb begin
    case (bus.addr)
      2'd0:    bus.rdata = 16'(r_pend);
      2'd1:    bus.rdata = 16'(r_mask);
      2'd2:    bus.rdata = 16'(r_edge);
      2'd3:    bus.rdata = {r_cur_valid, 11'd0, r_cur_id};
      default: bus.rdata = 16'd0;
    endcase
  end

  assign bus.irq = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic,
// compared every cycle against a cycle-level behavioural model.
module tb_irq_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_ctrl_if #(.N(N)) bus ();
  irq_ctrl #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // Model: src history (index 0 = sampled at last edge), registers, phase flags.
  logic [N-1:0] m_hist [0:2];
  logic [N-1:0] m_pend, m_mask, m_edge;
  logic         m_cur_valid;
  logic [3:0]   m_cur_id;
  logic         m_irq, m_wait, m_serv;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 16'(m_pend);
      2'd1:    return 16'(m_mask);
      2'd2:    return 16'(m_edge);
      default: return {m_cur_valid, 11'd0, m_cur_id};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_pend = '0; m_mask = '0; m_edge = '0;
    m_cur_valid = 1'b0; m_cur_id = 4'd0;
    m_irq = 1'b0; m_wait = 1'b0; m_serv = 1'b0;
  endtask

  // One rising edge of the model, using the inputs as the DUT sees them.
  task automatic model_edge();
    logic [N-1:0] s, rise, act, clr, np;
    logic idle, claim;
    int sel;
    s    = m_hist[1];
    rise = m_hist[1] & ~m_hist[2];
    act  = m_pend & m_mask;
    idle = !m_irq && !m_wait && !m_serv;
    claim = idle && bus.irq_en && (act != '0);
    sel = 0;
    for (int i = N - 1; i >= 0; i--) if (act[i]) sel = i;
    clr = '0;
    if (bus.we && bus.addr == 2'd0) clr = bus.wdata[N-1:0];
    if (claim && m_edge[sel]) clr[sel] = 1'b1;
    for (int i = 0; i < N; i++)
      np[i] = m_edge[i] ? ((m_pend[i] && !clr[i]) || rise[i]) : s[i];
    m_pend = np;
    if (bus.we && bus.addr == 2'd1) m_mask = bus.wdata[N-1:0];
    if (bus.we && bus.addr == 2'd2) m_edge = bus.wdata[N-1:0];
    if (claim) begin
      m_irq = 1'b1; m_cur_valid = 1'b1; m_cur_id = 4'(sel);
    end else if (m_irq) begin
      m_irq = 1'b0; m_wait = 1'b1;
    end else if (m_wait && !bus.irq_en) begin
      m_wait = 1'b0; m_serv = 1'b1;
    end else if (m_serv && bus.irq_en) begin
      m_serv = 1'b0; m_cur_valid = 1'b0;
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = bus.src;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("irq", {15'd0, bus.irq}, {15'd0, m_irq});
    check("rdata", bus.rdata, model_read(bus.addr));
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    step();
    bus.we = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    bus.src = v;
    step();
    bus.src = '0;
  endtask

  task automatic wait_irq(input string tag, input int lim, output int n);
    n = 0;
    for (int k = 1; k <= lim; k++) begin
      step();
      if (bus.irq === 1'b1) begin
        n = k;
        break;
      end
    end
    check(tag, {15'd0, (n != 0)}, 16'd1);
  endtask

  task automatic core_ack();
    step();
    bus.irq_en = 1'b0;
    step();
    bus.irq_en = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int seen;
    int hold;
    logic drop_pending;
    rst = 1'b1;
    bus.src = '0; bus.irq_en = 1'b0; bus.addr = 2'd0; bus.we = 1'b0; bus.wdata = 16'd0;
    model_reset();
    #22;
    @(negedge clk);
    rst = 1'b0;
    bus.irq_en = 1'b1;
    check("reset_irq", {15'd0, bus.irq}, 16'd0);
    rd(2'd0, 16'h0000, "reset_pend");
    rd(2'd1, 16'h0000, "reset_mask");
    rd(2'd2, 16'h0000, "reset_edge");
    rd(2'd3, 16'h0000, "reset_cur");

    // Edge source 2: latency and claim record.
    wr(2'd1, 16'h0004);
    wr(2'd2, 16'h0004);
    pulse(8'h04);
    wait_irq("edge_wait", 8, n);
    check("edge_latency", 16'(n + 1), 16'd4);
    rd(2'd3, 16'h8002, "edge_cur");
    rd(2'd0, 16'h0000, "edge_pend");
    core_ack();
    rd(2'd3, 16'h0002, "edge_cur_after");

    // Priority between sources 5 and 1.
    wr(2'd2, 16'h0022);
    wr(2'd1, 16'h0022);
    pulse(8'h22);
    wait_irq("prio_wait1", 8, n);
    rd(2'd3, 16'h8001, "prio_cur1");
    rd(2'd0, 16'h0020, "prio_pend1");
    core_ack();
    wait_irq("prio_wait2", 4, n);
    check("prio_refire", 16'(n), 16'd1);
    rd(2'd3, 16'h8005, "prio_cur2");
    core_ack();

    // Masking, then unmasking.
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0001);
    pulse(8'h01);
    repeat (6) step();
    rd(2'd0, 16'h0001, "mask_pend");
    wr(2'd1, 16'h0001);
    wait_irq("mask_wait", 4, n);
    rd(2'd3, 16'h8000, "mask_cur");
    core_ack();

    // irq_en gating.
    bus.irq_en = 1'b0;
    pulse(8'h01);
    repeat (8) step();
    rd(2'd0, 16'h0001, "gate_pend");
    bus.irq_en = 1'b1;
    wait_irq("gate_wait", 4, n);
    check("gate_latency", 16'(n), 16'd1);
    core_ack();

    // W1C on the same edge that PEND sets.
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0008);
    bus.src = 8'h08;
    step();
    step();
    wr(2'd0, 16'h0008);
    rd(2'd0, 16'h0008, "w1c_race");
    wr(2'd0, 16'h0008);
    rd(2'd0, 16'h0000, "w1c_clear");
    bus.src = '0;
    repeat (3) step();

    // Level mode.
    wr(2'd2, 16'h0000);
    wr(2'd1, 16'h0001);
    bus.src = 8'h01;
    wait_irq("lvl_wait1", 8, n);
    core_ack();
    wait_irq("lvl_wait2", 4, n);
    wr(2'd0, 16'h0001);
    rd(2'd0, 16'h0001, "lvl_w1c");
    bus.src = '0;
    core_ack();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.irq === 1'b1) seen++;
    end
    check("lvl_quiet", 16'(seen), 16'd0);
    rd(2'd0, 16'h0000, "lvl_pend_low");

    // Reset while irq is high.
    wr(2'd2, 16'h0004);
    wr(2'd1, 16'h0004);
    pulse(8'h04);
    wait_irq("rst_wait", 8, n);
    rst = 1'b1;
    #1;
    check("rst_irq_async", {15'd0, bus.irq}, 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rd(2'd0, 16'h0000, "rst_pend");
    rd(2'd1, 16'h0000, "rst_mask");
    rd(2'd2, 16'h0000, "rst_edge");
    rd(2'd3, 16'h0000, "rst_cur");

    // Random traffic with a core that acknowledges every request.
    drop_pending = 1'b0;
    hold = 0;
    bus.irq_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (bus.irq === 1'b1) drop_pending = 1'b1;
      else if (drop_pending) begin
        bus.irq_en = 1'b0;
        hold = $urandom_range(1, 6);
        drop_pending = 1'b0;
      end else if (!bus.irq_en) begin
        if (hold > 0) hold--;
        else bus.irq_en = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        bus.src[b] = ~bus.src[b];
      end
      bus.addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        bus.we = 1'b1;
        bus.wdata = 16'($urandom);
      end else begin
        bus.we = 1'b0;
      end
      step();
    end
    bus.we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that sits in front of the core's interrupt request input and drives the core's `irq_in`, following the core-side handshake: a single-cycle request pulse, then `irq_en` dropping and later returning. It collects up to 15 peripheral interrupt lines, latches them as pending, applies a mask, and picks the lowest-numbered active source. It records that source's number so the handler can read it over a small memory-mapped register port.

## Interface

Parameters:
- `N`, 8 — number of interrupt sources, legal range 1..15.

Ports:
- `clk`  in  1 — clock.
- `rst`  in  1 — reset, asynchronous, active-high.
- `src`  in  N — raw peripheral interrupt lines, asynchronous to `clk`.
- `irq_en`  in  1 — core interrupt-enable state (core rt_mode bit 2).
- `irq`  out  1 — request to core `irq_in`, registered.
- `addr`  in  2 — register select.
- `we`  in  1 — register write strobe, one cycle per write.
- `wdata`  in  16 — write data.
- `rdata`  out  16 — read data, combinational from `addr`.

## Operation

- Each `src[i]` passes through a 2-FF synchronizer, giving `s[i]`. An edge detector keeps the previous `s` value.
- `EDGE[i]=1` selects rising-edge mode: `PEND[i]` sets on a rising edge of `s[i]` and holds until it is cleared.
- `EDGE[i]=0` selects level mode: `PEND[i]` equals `s[i]` every cycle, and W1C has no effect.
- Register map:
  - 0 PEND: read returns pending bits; writing 1 clears the bit (W1C).
  - 1 MASK: read/write; 1 enables the source.
  - 2 EDGE: read/write.
  - 3 CUR: read-only; bit15 = valid, [3:0] = id of the last claimed source.
- Unused upper bits read 0. Writes to bits at or above N, and writes to CUR, are ignored.
- `act = PEND & MASK`. `sel` = index of the lowest set bit of `act`.
- FSM:
  - IDLE → FIRE when `irq_en=1` and `act!=0`. On this transition:
    - latch CUR = {1, sel};
    - if `EDGE[sel]`, clear `PEND[sel]`.
  - FIRE → WAIT_DIS, unconditionally after one cycle. `irq=1` only in FIRE.
  - WAIT_DIS → SERVICE when `irq_en=0`.
  - SERVICE → IDLE when `irq_en=1`, i.e. the handler re-enabled interrupts.
- CUR.valid clears on the SERVICE → IDLE transition. CUR.id is retained.
- Simultaneous set and clear on the same cycle (edge set vs. W1C, or edge set vs. claim clear): the set wins.
- A source that stays active after the claim fires again after the next return to IDLE.
- MASK changes take effect on the next IDLE evaluation. A claim already made is never revoked.

## Timing

- Reset values:
  - `irq=0`;
  - PEND, MASK, EDGE = 0;
  - CUR = 0;
  - state IDLE;
  - `rdata` reflects the reset registers.
- Latency from a `src` change (setup met) to the request, counted in rising edges with all conditions met:
  - edge 1: sync FF1 captures the change;
  - edge 2: FF2 captures it;
  - edge 3: PEND set;
  - edge 4: state enters FIRE and `irq=1`.
- `irq` is high for exactly one cycle per claim and is never asserted twice without passing through SERVICE.
- The core drops `irq_en` one cycle after `irq` falls; WAIT_DIS waits with no timeout.
- A register write takes effect on the edge where `we=1`. A read of the same register in that cycle returns the old value.
- `rst` asserted mid-sequence, in any state: returns to IDLE immediately and `irq` goes low asynchronously.

## Test plan

- Edge source: MASK=0x0004, EDGE=0x0004, pulse `src[2]` with `irq_en=1`.
  - `irq` rises 4 edges later for exactly 1 cycle; CUR=0x8002; PEND=0.
  - Drop `irq_en` → SERVICE; raise `irq_en` → CUR=0x0002.
- Priority: edge sources 5 and 1 set in the same cycle, both masked in.
  - First claim gives CUR id=1 while PEND bit5 stays set.
  - After the enable cycle completes, a second single-cycle `irq` gives id=5.
- Masking and gating:
  - MASK=0 with `src[0]` pulsed → no `irq`; PEND=0x0001. Then write MASK=1 → `irq` fires.
  - With `irq_en=0`, `irq` is held off until `irq_en` rises.
- W1C race: write PEND=0x0008 on the same cycle as a rising edge of `s[3]` → PEND bit3 remains 1.
- Level mode: `src[0]` held high, EDGE=0, MASK=1.
  - Fires, then re-fires after each full enable cycle.
  - Writing PEND=1 leaves the bit set.
  - `src[0]` low → PEND=0, no further `irq`.
- Reset mid-FIRE: assert `rst` while `irq=1` → `irq`=0 at once; all registers read 0 after release.
